// File: rtl/mso_dsp_pkg.sv
// Shared DSP helpers for the MSO acquisition path: sample widths and CIC
// register-growth arithmetic.
package mso_dsp_pkg;

    localparam int ADC_WIDTH     = 12;
    localparam int CAPTURE_WIDTH = 16;

    typedef enum logic {
        STAGE_INTEG = 1'b0,
        STAGE_COMB  = 1'b1
    } stage_kind_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Bit growth of an N-stage CIC with ratio R and differential delay M.
    function automatic int cic_width(input int in_width, input int stages,
                                     input int decim, input int diff_delay);
        return in_width + stages * clog2(decim * diff_delay);
    endfunction

endpackage

// File: rtl/mso_cic_decimator_if.sv
// Sample stream between the acquisition front end and the CIC decimator.
interface mso_cic_decimator_if
    import mso_dsp_pkg::*;
#(
    parameter int IN_WIDTH  = ADC_WIDTH,
    parameter int OUT_WIDTH = CAPTURE_WIDTH
);
    logic                 enabled;
    logic [IN_WIDTH-1:0]  data_in;
    logic                 clk_transfer;
    logic [OUT_WIDTH-1:0] data_out;

    modport master (
        output enabled,
        output data_in,
        input  clk_transfer,
        input  data_out
    );

    modport slave (
        input  enabled,
        input  data_in,
        output clk_transfer,
        output data_out
    );
endinterface

// File: rtl/mso_cic_decimator_cic_stage.sv
// One CIC cell: an accumulating integrator, or a comb that subtracts its input
// delayed by DELAY enabled cycles. Both modes share one register array.
module cic_stage
    import mso_dsp_pkg::*;
#(
    parameter int          W     = 16,
    parameter stage_kind_e KIND  = STAGE_INTEG,
    parameter int          DELAY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    // Integrator keeps a single accumulator; comb keeps a DELAY-deep history.
    localparam int DEPTH = (KIND == STAGE_COMB) ? DELAY : 1;

    logic [W-1:0] reg_q [DEPTH];
    logic [W-1:0] reg_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            reg_d[i] = reg_q[i];
        end
        if (en) begin
            if (KIND == STAGE_INTEG) begin
                reg_d[0] = reg_q[0] + din;
            end else begin
                reg_d[0] = din;
                for (int i = 1; i < DEPTH; i++) begin
                    reg_d[i] = reg_q[i-1];
                end
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                reg_q[gi] <= '0;
            end else begin
                reg_q[gi] <= reg_d[gi];
            end
        end
    end

    assign dout = (KIND == STAGE_INTEG) ? reg_q[0] : din - reg_q[DEPTH-1];

endmodule

// File: rtl/mso_cic_decimator.sv
// CIC decimator: STAGES integrators at the sample rate, STAGES combs at the
// decimated rate, plus the divided clk_transfer that paces capture.
module mso_cic_decimator
    import mso_dsp_pkg::*;
#(
    parameter int IN_WIDTH   = ADC_WIDTH,
    parameter int OUT_WIDTH  = CAPTURE_WIDTH,
    parameter int STAGES     = 2,
    parameter int DECIM      = 4,
    parameter int DIFF_DELAY = 1
) (
    input logic                clk,
    input logic                rst_n,
    mso_cic_decimator_if.slave bus
);
    localparam int W     = cic_width(IN_WIDTH, STAGES, DECIM, DIFF_DELAY);
    localparam int CNT_W = clog2(DECIM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DECIM / 2 - 1);

    logic [W-1:0]         integ_w [STAGES+1];
    logic [W-1:0]         comb_w  [STAGES+1];
    logic [OUT_WIDTH-1:0] scaled;
    logic                 tick;

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] data_out_q, data_out_d;
    logic                 clk_transfer_q, clk_transfer_d;

    assign integ_w[0] = {{(W - IN_WIDTH){bus.data_in[IN_WIDTH-1]}}, bus.data_in};
    assign comb_w[0]  = integ_w[STAGES];
    assign tick       = bus.enabled && (cnt_q == CNT_LAST);

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        cic_stage #(.W(W), .KIND(STAGE_INTEG), .DELAY(DIFF_DELAY)) u_integ (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (bus.enabled),
            .din  (integ_w[gi]),
            .dout (integ_w[gi+1])
        );
        cic_stage #(.W(W), .KIND(STAGE_COMB), .DELAY(DIFF_DELAY)) u_comb (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (tick),
            .din  (comb_w[gi]),
            .dout (comb_w[gi+1])
        );
    end

    // Keep the top OUT_WIDTH bits; narrower internal paths are sign-extended.
    if (W >= OUT_WIDTH) begin : g_trunc
        assign scaled = comb_w[STAGES][W-1 -: OUT_WIDTH];
    end else begin : g_extend
        assign scaled = {{(OUT_WIDTH - W){comb_w[STAGES][W-1]}}, comb_w[STAGES]};
    end

    always_comb begin
        cnt_d          = cnt_q;
        data_out_d     = data_out_q;
        clk_transfer_d = clk_transfer_q;
        if (tick) begin
            cnt_d          = '0;
            data_out_d     = scaled;
            clk_transfer_d = 1'b1;
        end else if (bus.enabled) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_HALF) begin
                clk_transfer_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            data_out_q     <= '0;
            clk_transfer_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            data_out_q     <= data_out_d;
            clk_transfer_q <= clk_transfer_d;
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.clk_transfer = clk_transfer_q;

endmodule

// File: tb/tb_mso_cic_decimator.sv
// Bench for mso_cic_decimator: FIR-equivalent model (boxcar^N, decimated)
// checked every cycle, plus hand-computed literal expectations.
module tb_mso_cic_decimator;

    localparam int N    = 2;
    localparam int R    = 4;
    localparam int M    = 1;
    localparam int RM   = R * M;
    localparam int HLEN = N * (RM - 1) + 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mso_cic_decimator_if #(.IN_WIDTH(12), .OUT_WIDTH(16)) bus ();

    mso_cic_decimator #(
        .IN_WIDTH  (12),
        .OUT_WIDTH (16),
        .STAGES    (N),
        .DECIM     (R),
        .DIFF_DELAY(M)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the CIC equals an FIR with taps boxcar(RM) convolved N times,
    // with N samples of integrator latency, evaluated on every R-th sample.
    int          h [HLEN];
    int          hist [$];
    logic [15:0] exp_data;
    logic        exp_ct;

    task automatic build_h();
        int prev [HLEN];
        h    = '{default: 0};
        h[0] = 1;
        for (int s = 0; s < N; s++) begin
            prev = h;
            for (int k = 0; k < HLEN; k++) begin
                h[k] = 0;
                for (int t = 0; t < RM; t++) begin
                    if (k - t >= 0) h[k] += prev[k - t];
                end
            end
        end
    endtask

    task automatic model_clear();
        hist.delete();
        exp_data = 16'h0000;
        exp_ct   = 1'b0;
    endtask

    task automatic model_step(input int x);
        int n;
        int y;
        int idx;
        n = hist.size();
        hist.push_back(x);
        if (n % R == R - 1) begin
            y = 0;
            for (int j = 0; j < HLEN; j++) begin
                idx = n - N - j;
                if (idx >= 0) y += h[j] * hist[idx];
            end
            exp_data = 16'(y);
        end
        exp_ct = (n + 1 >= R) && (((n + 1) % R) < R / 2);
    endtask

    task automatic cycle(input logic en, input int x);
        bus.enabled = en;
        bus.data_in = 12'(x);
        @(posedge clk);
        if (rst_n && en) model_step(x);
        #1;
    endtask

    task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%h (%0d), expected 0x%h (%0d)", name, got, $signed(got), want, $signed(want));
        end else begin
            $display("ok   %s: data 0x%h (%0d)", name, got, $signed(got));
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, got, want);
        end else begin
            $display("ok   %s: %b", name, got);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        cycle(1'b1, 7);
        cycle(1'b1, -7);
        rst_n = 1'b1;
    endtask

    // Sequence run, optionally freezing enabled for 7 cycles after drop_at samples.
    task automatic run_seq(input int drop_at);
        int seq [10];
        int lit [5];
        int k;
        seq = '{0, -3, 1, 0, -2, -1, 4, -5, 6, 0};
        lit = '{-3, -10, 6, 7, 0};
        do_reset();
        k = 0;
        while (k < 20) begin
            if (k == drop_at) begin
                repeat (7) cycle(1'b0, 99);
            end
            cycle(1'b1, (k < 10) ? seq[k] : 0);
            k++;
            if (k % R == 0) check_val($sformatf("seq drop=%0d tick%0d", drop_at, k / R), bus.data_out, 16'(lit[k / R - 1]));
        end
    endtask

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if (bus.data_out !== exp_data) begin
                errors++;
                $display("FAIL data_out at %0t: got 0x%h, expected 0x%h", $time, bus.data_out, exp_data);
            end
            checks++;
            if (bus.clk_transfer !== exp_ct) begin
                errors++;
                $display("FAIL clk_transfer at %0t: got %b, expected %b", $time, bus.clk_transfer, exp_ct);
            end
        end
    end

    initial begin
        int v;
        int sum;
        checks = 0;
        errors = 0;
        build_h();
        model_clear();
        rst_n       = 1'b0;
        bus.enabled = 1'b1;
        bus.data_in = 12'd5;
        #100;
        check_val("reset data_out", bus.data_out, 16'h0000);
        check_bit("reset clk_transfer", bus.clk_transfer, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Constant 1: ticks give 3, 15, then the DC gain 16.
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 1);
            if (i == 4)  check_val("dc1 tick1", bus.data_out, 16'd3);
            if (i == 8)  check_val("dc1 tick2", bus.data_out, 16'd15);
            if (i == 12) check_val("dc1 tick3", bus.data_out, 16'h0010);
            if (i == 16) check_val("dc1 tick4", bus.data_out, 16'h0010);
            if (i >= 12 && i <= 15) check_bit($sformatf("clk_transfer phase %0d", i - 12), bus.clk_transfer, (i < 14));
        end

        // Asynchronous clear between clock edges.
        rst_n = 1'b0;
        model_clear();
        #1;
        check_val("async clear data_out", bus.data_out, 16'h0000);
        check_bit("async clear clk_transfer", bus.clk_transfer, 1'b0);
        cycle(1'b1, 7);
        cycle(1'b1, 7);
        rst_n = 1'b1;

        // Impulse at each of the R phases: outputs non-negative, decay to 0, total 16.
        sum = 0;
        for (int p = 0; p < R; p++) begin
            do_reset();
            v = 0;
            for (int i = 0; i < 16; i++) begin
                cycle(1'b1, (i == p) ? 1 : 0);
                if ((i + 1) % R == 0) begin
                    v = $signed(bus.data_out);
                    checks++;
                    if (v < 0) begin
                        errors++;
                        $display("FAIL impulse p%0d sign: got %0d, expected >= 0", p, v);
                    end
                    sum += v;
                end
            end
            check_val($sformatf("impulse p%0d settles", p), bus.data_out, 16'h0000);
        end
        checks++;
        if (sum != 16) begin
            errors++;
            $display("FAIL impulse sum: got %0d, expected 16", sum);
        end else begin
            $display("ok   impulse sum: %0d", sum);
        end

        // Full scale with long runs so the integrators wrap repeatedly.
        do_reset();
        repeat (1000) cycle(1'b1, -2048);
        check_val("full scale negative", bus.data_out, 16'h8000);
        repeat (1000) cycle(1'b1, 2047);
        check_val("full scale positive", bus.data_out, 16'h7FF0);

        run_seq(-1);
        run_seq(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
